sc_pointdatapath: RTL and testbench
===================================

Name: sc_pointdatapath

Overview:
- Datapath at the far end of the point state machine's control interface.
- Holds the position of a single lit point on an 8x8 LED matrix and executes the state machine's active-low clear, load0 (up) and load1 (down) strobes and its shiftselection code (left/right).
- Returns the bottom-side comparator flag that the state machine uses to gate down moves.
- Drives a time-multiplexed row scan of the matrix.

Parameters:
- ROWS, 8, number of matrix rows; row 0 is the top.
- COLS, 8, number of matrix columns; bit 0 is the rightmost column.
- INIT_COL, 3, column of the point after reset or clear.
- SCAN_DIV, 50000, clock cycles spent on each scanned row; must be at least 1.

Ports:
- SC_STATEMACHINEPOINT_CLOCK_50  in  1  system clock, 50 MHz
- SC_STATEMACHINEPOINT_RESET_InHigh  in  1  asynchronous reset, active-high
- point_clear_InLow  in  1  return point to its initial position
- point_load0_InLow  in  1  move point up one row
- point_load1_InLow  in  1  move point down one row
- point_shiftselection_In  in  2  01 = left, 10 = right, 11 = hold, 00 = hold (reserved)
- bottomsidecomparator_OutLow  out  1  0 when point is on row ROWS-1
- topsidecomparator_OutLow  out  1  0 when point is on row 0
- point_row_Out  out  3  current row index
- point_col_Out  out  COLS  current column, one-hot
- matrix_row_Out  out  ROWS  one-hot, active-high select of the scanned row
- matrix_col_Out  out  COLS  column data for the scanned row

Behaviour:
- Reset SC_STATEMACHINEPOINT_RESET_InHigh, asynchronous, active-high; clock SC_STATEMACHINEPOINT_CLOCK_50.
- Reset state:
  - row_q = 0; col_q = one-hot(INIT_COL), i.e. 8'b0000_1000.
  - Scan row = 0; prescaler = 0.
  - Resulting outputs: bottomsidecomparator_OutLow = 1, topsidecomparator_OutLow = 0, point_row_Out = 0, point_col_Out = 8'h08, matrix_row_Out = 8'h01, matrix_col_Out = 8'h08.
- All commands are sampled on the rising clock edge; the effect appears on the outputs after exactly 1 cycle.
  - Each command is a 1-cycle strobe.
  - A command held for N cycles executes N times.
- Priority when several commands are active in the same cycle: clear > load0 > load1 > shift. Only the winning command executes; the rest are dropped.
- Clear: row_q <= 0, col_q <= one-hot(INIT_COL). The scan counters are not affected.
- Up (load0 = 0): row_q <= row_q - 1 when row_q > 0; at row 0 the position holds (no wrap).
- Down (load1 = 0): row_q <= row_q + 1 when row_q < ROWS-1; at ROWS-1 the position holds. The datapath saturates regardless of upstream gating.
- Left (shiftselection = 01): col_q <= col_q << 1 unless col_q[COLS-1] = 1, in which case it holds.
- Right (shiftselection = 10): col_q <= col_q >> 1 unless col_q[0] = 1, in which case it holds.
- col_q is always exactly one-hot; no command may produce zero bits set or more than one bit set.
- Comparators are combinational from row_q:
  - bottomsidecomparator_OutLow = !(row_q == ROWS-1).
  - topsidecomparator_OutLow = !(row_q == 0).
- Scan:
  - The prescaler counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap cycle, the scan row advances by 1 modulo ROWS (7 -> 0).
  - matrix_row_Out = one-hot(scan row).
  - matrix_col_Out = col_q when scan row == row_q, otherwise 0.
  - Both are combinational from registers and glitch-free relative to the clock.
- Reset asserted mid-operation (during a command or mid-scan) immediately forces every register to its reset value. The first command after deassertion executes normally.

Decomposition:
- Shared package holds:
  - Shift-select constants: SHIFT_LEFT = 2'b01, SHIFT_RIGHT = 2'b10, SHIFT_HOLD = 2'b11.
  - Default ROWS, COLS and INIT_COL values, so the point state machine and this block share one definition.
- One natural sub-module: sc_scancounter.
  - Contains the prescaler and the row counter.
  - Parameters: SCAN_DIV, ROWS.
  - Outputs: scan row index and wrap tick.
- The point register and comparators stay in the top level.

Test Plan:
- Reset, then hold idle inputs (all 1, shift = 11) -> point_row_Out = 0, point_col_Out = 8'h08, topsidecomparator_OutLow = 0, bottomsidecomparator_OutLow = 1.
- Eight 1-cycle load1 strobes -> point_row_Out steps 1..7 and holds at 7; bottomsidecomparator_OutLow = 0 from the 7th strobe onward.
- Six 1-cycle shift = 01 strobes from column 3 -> point_col_Out = 10, 20, 40, 80, 80, 80. Then eight shift = 10 strobes -> steps down to 8'h01 and holds.
- Same cycle: clear = 0, load1 = 0, shift = 01, with the point at row 5, col 8'h40 -> next cycle row 0, col 8'h08. Then load0 = 0 with load1 = 0 together -> row stays 0.
- With SCAN_DIV = 4 and the point at row 2: matrix_row_Out advances every 4 cycles, 01 -> 02 -> 04 ... 80 -> 01. matrix_col_Out = point_col_Out only while matrix_row_Out = 8'h04, else 0.
- Assert reset for 1 cycle while at row 6, col 8'h80, mid-scan -> all outputs return to reset values immediately. A load1 strobe after release -> row 1.

Source files
------------

// File: rtl/sc_pointdatapath_pkg.sv
// Definitions shared between the point state machine and its datapath:
// the shift-select encoding and the default matrix geometry.
package sc_pointdatapath_pkg;

    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_HOLD  = 2'b11;

    localparam int DEFAULT_ROWS     = 8;
    localparam int DEFAULT_COLS     = 8;
    localparam int DEFAULT_INIT_COL = 3;

endpackage

// File: rtl/sc_pointdatapath_scancounter.sv
// Row scan timebase: a prescaler that wraps every SCAN_DIV cycles and a
// row counter that advances by one row on each prescaler wrap.
module sc_scancounter #(
    parameter int SCAN_DIV = 50000,
    parameter int ROWS     = 8,
    localparam int PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    output logic [RW-1:0] scan_row,
    output logic          scan_tick
);

    logic [PW-1:0] presc_q, presc_d;
    logic [RW-1:0] row_q, row_d;

    assign scan_tick = (presc_q == PW'(SCAN_DIV - 1));
    assign scan_row  = row_q;

    always_comb begin
        presc_d = presc_q + 1'b1;
        row_d   = row_q;
        if (scan_tick) begin
            presc_d = '0;
            row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            row_q   <= '0;
        end else begin
            presc_q <= presc_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: rtl/sc_pointdatapath.sv
// Point datapath: holds one lit point on the LED matrix, executes the state
// machine's move strobes, reports edge comparators and drives the row scan.
module sc_pointdatapath
    import sc_pointdatapath_pkg::*;
#(
    parameter int ROWS     = DEFAULT_ROWS,
    parameter int COLS     = DEFAULT_COLS,
    parameter int INIT_COL = DEFAULT_INIT_COL,
    parameter int SCAN_DIV = 50000
) (
    input  logic            SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic            SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic            point_clear_InLow,
    input  logic            point_load0_InLow,
    input  logic            point_load1_InLow,
    input  logic [1:0]      point_shiftselection_In,
    output logic            bottomsidecomparator_OutLow,
    output logic            topsidecomparator_OutLow,
    output logic [2:0]      point_row_Out,
    output logic [COLS-1:0] point_col_Out,
    output logic [ROWS-1:0] matrix_row_Out,
    output logic [COLS-1:0] matrix_col_Out
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COLS-1:0] INIT_ONEHOT = COLS'(1) << INIT_COL;

    logic [RW-1:0]   row_q, row_d;
    logic [COLS-1:0] col_q, col_d;
    logic [RW-1:0]   scan_row;
    logic            unused_scan_tick;

    // Only the highest-priority active command executes; edges saturate.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (!point_clear_InLow) begin
            row_d = '0;
            col_d = INIT_ONEHOT;
        end else if (!point_load0_InLow) begin
            if (row_q != '0) row_d = row_q - 1'b1;
        end else if (!point_load1_InLow) begin
            if (row_q != RW'(ROWS - 1)) row_d = row_q + 1'b1;
        end else begin
            case (point_shiftselection_In)
                SHIFT_LEFT:  if (!col_q[COLS-1]) col_d = col_q << 1;
                SHIFT_RIGHT: if (!col_q[0])      col_d = col_q >> 1;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
        if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
            row_q <= '0;
            col_q <= INIT_ONEHOT;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    sc_scancounter #(
        .SCAN_DIV (SCAN_DIV),
        .ROWS     (ROWS)
    ) u_scancounter (
        .clock     (SC_STATEMACHINEPOINT_CLOCK_50),
        .reset     (SC_STATEMACHINEPOINT_RESET_InHigh),
        .scan_row  (scan_row),
        .scan_tick (unused_scan_tick)
    );

    assign bottomsidecomparator_OutLow = !(row_q == RW'(ROWS - 1));
    assign topsidecomparator_OutLow    = !(row_q == '0);
    assign point_row_Out               = 3'(row_q);
    assign point_col_Out               = col_q;
    assign matrix_row_Out              = ROWS'(1) << scan_row;
    assign matrix_col_Out              = (scan_row == row_q) ? col_q : '0;

endmodule

// File: tb/tb_sc_pointdatapath.sv
// Directed self-checking bench for sc_pointdatapath with a short scan divider.
module tb_sc_pointdatapath;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_n = 1'b1;
    logic       load0_n = 1'b1;
    logic       load1_n = 1'b1;
    logic [1:0] shift = 2'b11;
    logic       bottom_n, top_n;
    logic [2:0] row_out;
    logic [7:0] col_out, mrow_out, mcol_out;

    int checks = 0;
    int errors = 0;

    sc_pointdatapath #(
        .ROWS(8), .COLS(8), .INIT_COL(3), .SCAN_DIV(4)
    ) dut (
        .SC_STATEMACHINEPOINT_CLOCK_50     (clk),
        .SC_STATEMACHINEPOINT_RESET_InHigh (rst),
        .point_clear_InLow                 (clear_n),
        .point_load0_InLow                 (load0_n),
        .point_load1_InLow                 (load1_n),
        .point_shiftselection_In           (shift),
        .bottomsidecomparator_OutLow       (bottom_n),
        .topsidecomparator_OutLow          (top_n),
        .point_row_Out                     (row_out),
        .point_col_Out                     (col_out),
        .matrix_row_Out                    (mrow_out),
        .matrix_col_Out                    (mcol_out)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1 time unit past the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle;
        clear_n = 1'b1;
        load0_n = 1'b1;
        load1_n = 1'b1;
        shift   = 2'b11;
    endtask

    // Leaves the scan prescaler at 0 and scan row 0 at the release point.
    task automatic do_reset;
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic strobe_load1;
        load1_n = 1'b0;
        tick();
        load1_n = 1'b1;
    endtask

    task automatic strobe_shift(input logic [1:0] code);
        shift = code;
        tick();
        shift = 2'b11;
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        tick();
        checks++;
        if (row_out !== 3'd0) begin errors++; $display("[TB] FAIL reset_row actual=%0d required=0", row_out); end
        checks++;
        if (col_out !== 8'h08) begin errors++; $display("[TB] FAIL reset_col actual=%h required=08", col_out); end
        checks++;
        if (top_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_top actual=%b required=0", top_n); end
        checks++;
        if (bottom_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_bottom actual=%b required=1", bottom_n); end
    endtask

    task automatic test_down;
        logic [2:0] exp_row;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            strobe_load1();
            exp_row = (i >= 7) ? 3'd7 : 3'(i);
            checks++;
            if (row_out !== exp_row) begin errors++; $display("[TB] FAIL down_row[%0d] actual=%0d required=%0d", i, row_out, exp_row); end
            checks++;
            if (bottom_n !== (i < 7)) begin errors++; $display("[TB] FAIL down_bottom[%0d] actual=%b required=%b", i, bottom_n, (i < 7)); end
            checks++;
            if (top_n !== 1'b1) begin errors++; $display("[TB] FAIL down_top[%0d] actual=%b required=1", i, top_n); end
            tick();
            checks++;
            if (row_out !== exp_row) begin errors++; $display("[TB] FAIL down_idle[%0d] actual=%0d required=%0d", i, row_out, exp_row); end
        end
    endtask

    task automatic test_shift;
        logic [7:0] left_exp [6]  = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h80, 8'h80};
        logic [7:0] right_exp [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            strobe_shift(2'b01);
            checks++;
            if (col_out !== left_exp[i]) begin errors++; $display("[TB] FAIL left[%0d] actual=%h required=%h", i, col_out, left_exp[i]); end
        end
        for (int i = 0; i < 8; i++) begin
            strobe_shift(2'b10);
            checks++;
            if (col_out !== right_exp[i]) begin errors++; $display("[TB] FAIL right[%0d] actual=%h required=%h", i, col_out, right_exp[i]); end
        end
        strobe_shift(2'b00);
        checks++;
        if (col_out !== 8'h01) begin errors++; $display("[TB] FAIL shift_00_hold actual=%h required=01", col_out); end
        checks++;
        if (row_out !== 3'd0) begin errors++; $display("[TB] FAIL shift_row actual=%0d required=0", row_out); end
    endtask

    task automatic test_priority;
        do_reset();
        for (int i = 0; i < 5; i++) strobe_load1();
        for (int i = 0; i < 3; i++) strobe_shift(2'b01);
        checks++;
        if (row_out !== 3'd5 || col_out !== 8'h40) begin errors++; $display("[TB] FAIL prio_setup actual=%0d/%h required=5/40", row_out, col_out); end
        clear_n = 1'b0; load1_n = 1'b0; shift = 2'b01;
        tick();
        set_idle();
        checks++;
        if (row_out !== 3'd0) begin errors++; $display("[TB] FAIL prio_clear_row actual=%0d required=0", row_out); end
        checks++;
        if (col_out !== 8'h08) begin errors++; $display("[TB] FAIL prio_clear_col actual=%h required=08", col_out); end
        load0_n = 1'b0; load1_n = 1'b0;
        tick();
        set_idle();
        checks++;
        if (row_out !== 3'd0) begin errors++; $display("[TB] FAIL prio_up_at_top actual=%0d required=0", row_out); end
        load1_n = 1'b0; shift = 2'b10;
        tick();
        set_idle();
        checks++;
        if (row_out !== 3'd1 || col_out !== 8'h08) begin errors++; $display("[TB] FAIL prio_down_over_shift actual=%0d/%h required=1/08", row_out, col_out); end
        strobe_load1();
        strobe_load1();
        load0_n = 1'b0; load1_n = 1'b0;
        tick();
        set_idle();
        checks++;
        if (row_out !== 3'd2) begin errors++; $display("[TB] FAIL prio_up_over_down actual=%0d required=2", row_out); end
    endtask

    task automatic test_scan;
        int srow;
        logic [7:0] exp_mrow, exp_mcol;
        do_reset();
        load1_n = 1'b0;
        tick();
        tick();
        load1_n = 1'b1;
        for (int k = 2; k <= 36; k++) begin
            if (k > 2) tick();
            srow     = (k / 4) % 8;
            exp_mrow = 8'h01 << srow;
            exp_mcol = (srow == 2) ? 8'h08 : 8'h00;
            checks++;
            if (mrow_out !== exp_mrow) begin errors++; $display("[TB] FAIL scan_row[k=%0d] actual=%h required=%h", k, mrow_out, exp_mrow); end
            checks++;
            if (mcol_out !== exp_mcol) begin errors++; $display("[TB] FAIL scan_col[k=%0d] actual=%h required=%h", k, mcol_out, exp_mcol); end
        end
        checks++;
        if (row_out !== 3'd2) begin errors++; $display("[TB] FAIL scan_point_row actual=%0d required=2", row_out); end
    endtask

    task automatic test_midop_reset;
        do_reset();
        for (int i = 0; i < 6; i++) strobe_load1();
        for (int i = 0; i < 4; i++) strobe_shift(2'b01);
        checks++;
        if (row_out !== 3'd6 || col_out !== 8'h80 || mrow_out !== 8'h04) begin
            errors++; $display("[TB] FAIL midrst_setup actual=%0d/%h/%h required=6/80/04", row_out, col_out, mrow_out);
        end
        load1_n = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (row_out !== 3'd0 || col_out !== 8'h08) begin errors++; $display("[TB] FAIL midrst_point actual=%0d/%h required=0/08", row_out, col_out); end
        checks++;
        if (top_n !== 1'b0 || bottom_n !== 1'b1) begin errors++; $display("[TB] FAIL midrst_cmp actual=%b/%b required=0/1", top_n, bottom_n); end
        checks++;
        if (mrow_out !== 8'h01 || mcol_out !== 8'h08) begin errors++; $display("[TB] FAIL midrst_matrix actual=%h/%h required=01/08", mrow_out, mcol_out); end
        set_idle();
        tick();
        rst = 1'b0;
        strobe_load1();
        checks++;
        if (row_out !== 3'd1) begin errors++; $display("[TB] FAIL midrst_first_cmd actual=%0d required=1", row_out); end
    endtask

    initial begin
        test_reset();
        test_down();
        test_shift();
        test_priority();
        test_scan();
        test_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
